// File: rtl/alu_seq_issue_pkg.sv
// alu_pkg: function codes, legality check and sequencer state encoding
package alu_pkg;
  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_AND = 3'b001;
  localparam logic [2:0] FUNC_OR  = 3'b010;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} stateT;
  function automatic logic func_legal(input logic [2:0] f);
    return f == FUNC_ADD || f == FUNC_AND || f == FUNC_OR;
  endfunction
endpackage

// File: rtl/alu_seq_issue_if.sv
// alu_seq_issue_if: request, ALU-side and response signals of the byte sequencer
interface alu_seq_issue_if #(parameter int NBYTES = 2);
  localparam int W = 8 * NBYTES;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [2:0]   req_func;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [2:0]   alu_func;
  logic [7:0]   alu_result;
  logic         alu_cout;
  logic         alu_zero;
  logic         alu_neg;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_neg;
  logic         rsp_err;
  modport slave (
    input  req_valid, req_a, req_b, req_func, alu_result, alu_cout, alu_zero, alu_neg, rsp_ready,
    output req_ready, alu_a, alu_b, alu_cin, alu_func, rsp_valid, rsp_result, rsp_carry, rsp_zero,
           rsp_neg, rsp_err
  );
  modport master (
    output req_valid, req_a, req_b, req_func, alu_result, alu_cout, alu_zero, alu_neg, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_cin, alu_func, rsp_valid, rsp_result, rsp_carry, rsp_zero,
           rsp_neg, rsp_err
  );
endinterface

// File: rtl/alu_seq_issue.sv
// alu_seq_issue: issues multi-byte operations to an 8-bit ALU one byte per cycle, LSB first
module alu_seq_issue
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_issue_if.slave bus
);
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  stateT                  state, nextState;
  logic [NBYTES-1:0][7:0] opA, opB, result, nextResult;
  logic [2:0]             func;
  logic [IW-1:0]          idx;
  logic                   carry, rspCarry, rspZero, rspNeg, rspErr;
  logic                   isAdd, isExec, lastByte, accept, unusedFlags;
  assign isAdd       = func == FUNC_ADD;
  assign isExec      = state == EXEC;
  assign lastByte    = idx == IW'(NBYTES - 1);
  assign accept      = bus.req_valid && bus.req_ready;
  assign unusedFlags = bus.alu_zero ^ bus.alu_neg;
  always_comb begin
    nextState       = state;
    nextResult      = result;
    nextResult[idx] = bus.alu_result;
    case (state)
      IDLE:    nextState = accept ? (func_legal(bus.req_func) ? EXEC : DONE) : IDLE;
      EXEC:    nextState = lastByte ? DONE : EXEC;
      DONE:    nextState = bus.rsp_ready ? IDLE : DONE;
      default: nextState = IDLE;
    endcase
  end
  assign bus.req_ready  = state == IDLE && !rst;
  assign bus.alu_a      = isExec ? opA[idx] : 8'h00;
  assign bus.alu_b      = isExec ? opB[idx] : 8'h00;
  assign bus.alu_func   = isExec ? func : FUNC_ADD;
  assign bus.alu_cin    = isExec && isAdd && carry;
  assign bus.rsp_valid  = state == DONE;
  assign bus.rsp_result = result;
  assign bus.rsp_carry  = rspCarry;
  assign bus.rsp_zero   = rspZero;
  assign bus.rsp_neg    = rspNeg;
  assign bus.rsp_err    = rspErr;
  // Flags are captured from the fully assembled word on the final byte so they stay stable in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opA      <= '0;
      opB      <= '0;
      result   <= '0;
      func     <= FUNC_ADD;
      idx      <= '0;
      carry    <= 1'b0;
      rspCarry <= 1'b0;
      rspZero  <= 1'b0;
      rspNeg   <= 1'b0;
      rspErr   <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        opA      <= bus.req_a;
        opB      <= bus.req_b;
        func     <= bus.req_func;
        idx      <= '0;
        carry    <= 1'b0;
        result   <= '0;
        rspCarry <= 1'b0;
        rspZero  <= 1'b0;
        rspNeg   <= 1'b0;
        rspErr   <= !func_legal(bus.req_func);
      end
      if (isExec) begin
        result <= nextResult;
        carry  <= isAdd && bus.alu_cout;
        idx    <= idx + 1'b1;
        if (lastByte) begin
          rspCarry <= isAdd && bus.alu_cout;
          rspZero  <= nextResult == '0;
          rspNeg   <= nextResult[NBYTES-1][7];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_issue.sv
// tb_alu_seq_issue: directed vectors plus a cycle-level reference model of the sequencer
module tb_alu_seq_issue;
  localparam int NB = 2;
  localparam int W  = 8 * NB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic chkOn = 1'b0;
  alu_seq_issue_if #(.NBYTES(NB)) bus ();
  alu_seq_issue #(.NBYTES(NB)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [8:0] aluSum;
  always_comb begin
    aluSum         = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 9'(bus.alu_cin);
    bus.alu_result = bus.alu_func == 3'b000 ? aluSum[7:0] :
                     bus.alu_func == 3'b001 ? (bus.alu_a & bus.alu_b) :
                     bus.alu_func == 3'b010 ? (bus.alu_a | bus.alu_b) : 8'h00;
    bus.alu_cout   = bus.alu_func == 3'b000 && aluSum[8];
    bus.alu_zero   = bus.alu_result == 8'h00;
    bus.alu_neg    = bus.alu_result[7];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: one op in flight, tracked only by its operands and cycles since acceptance
  logic         mBusy = 1'b0;
  int           mAge = 0;
  logic [W-1:0] mA = '0, mB = '0;
  logic [2:0]   mF = 3'b000;
  logic         expLegal, expValid, expExec, expCin;
  logic [W:0]   full;
  logic [7:0]   expA, expB;
  logic [31:0]  lowA, lowB, lowMask;
  int           k;
  always_comb begin
    expLegal = mF inside {3'b000, 3'b001, 3'b010};
    expValid = mBusy && mAge >= (expLegal ? NB + 1 : 1);
    expExec  = mBusy && expLegal && mAge >= 1 && mAge <= NB;
    k        = expExec ? mAge - 1 : 0;
    full     = mF == 3'b000 ? {1'b0, mA} + {1'b0, mB} :
               mF == 3'b001 ? {1'b0, mA & mB} :
               mF == 3'b010 ? {1'b0, mA | mB} : '0;
    lowMask  = (32'd1 << (8 * k)) - 32'd1;
    lowA     = 32'(mA) & lowMask;
    lowB     = 32'(mB) & lowMask;
    expA     = expExec ? 8'(mA >> (8 * k)) : 8'h00;
    expB     = expExec ? 8'(mB >> (8 * k)) : 8'h00;
    expCin   = expExec && mF == 3'b000 && (((lowA + lowB) >> (8 * k)) & 32'd1) != 0;
  end
  always @(posedge clk) begin
    if (rst) mBusy <= 1'b0;
    else if (!mBusy) begin
      if (bus.req_valid) begin
        mBusy <= 1'b1;
        mAge  <= 1;
        mA    <= bus.req_a;
        mB    <= bus.req_b;
        mF    <= bus.req_func;
      end
    end else if (expValid && bus.rsp_ready) mBusy <= 1'b0;
    else mAge <= mAge + 1;
  end
  always @(negedge clk) begin
    if (chkOn) begin
      chk("req_ready", 32'(bus.req_ready), 32'(!mBusy && !rst));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(expValid));
      chk("alu_a", 32'(bus.alu_a), 32'(expA));
      chk("alu_b", 32'(bus.alu_b), 32'(expB));
      chk("alu_cin", 32'(bus.alu_cin), 32'(expCin));
      chk("alu_func", 32'(bus.alu_func), 32'(expExec ? mF : 3'b000));
      if (expValid) begin
        chk("rsp_result", 32'(bus.rsp_result), expLegal ? 32'(full[W-1:0]) : 32'd0);
        chk("rsp_carry", 32'(bus.rsp_carry), 32'(expLegal && full[W]));
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(expLegal && full[W-1:0] == '0));
        chk("rsp_neg", 32'(bus.rsp_neg), 32'(expLegal && full[W-1]));
        chk("rsp_err", 32'(bus.rsp_err), 32'(!expLegal));
      end
    end
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_func  = f;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic waitRsp(input string nm, input int want);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 20);
    chk(nm, 32'(n), 32'(want));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_func  = 3'b000;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    chkOn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 0);
    chk("rst_rsp_flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_neg, bus.rsp_err}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1 issue(16'h00FF, 16'h0001, 3'b000);
    @(negedge clk);
    chk("lo_alu_ab", 32'({bus.alu_a, bus.alu_b}), 32'h FF01);
    chk("lo_alu_cin", 32'(bus.alu_cin), 0);
    @(negedge clk);
    chk("hi_alu_ab", 32'({bus.alu_a, bus.alu_b}), 32'h0000);
    chk("hi_alu_cin", 32'(bus.alu_cin), 1);
    @(negedge clk);
    chk("add1_valid", 32'(bus.rsp_valid), 1);
    chk("add1_result", 32'(bus.rsp_result), 32'h0100);
    chk("add1_flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_neg}), 0);
    @(posedge clk);
    #1 issue(16'hFFFF, 16'h0001, 3'b000);
    waitRsp("add2_latency", 3);
    chk("add2_result", 32'(bus.rsp_result), 0);
    chk("add2_flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_neg}), 32'b110);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    issue(16'hF0F0, 16'h8FF0, 3'b001);
    @(negedge clk);
    chk("and_lo_cin", 32'(bus.alu_cin), 0);
    @(negedge clk);
    chk("and_hi_cin", 32'(bus.alu_cin), 0);
    chk("and_hi_ab", 32'({bus.alu_a, bus.alu_b}), 32'hF08F);
    @(negedge clk);
    chk("and_result", 32'(bus.rsp_result), 32'h80F0);
    chk("and_flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_neg}), 32'b001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", 32'(bus.rsp_result), 32'h80F0);
      chk("hold_valid_ready", 32'({bus.rsp_valid, bus.req_ready, bus.rsp_neg}), 32'b101);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("ready_before_accept", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1 chk("ready_after_accept", 32'(bus.req_ready), 1);
    issue(16'h1200, 16'h0034, 3'b010);
    waitRsp("or_latency", 3);
    chk("or_result", 32'(bus.rsp_result), 32'h1234);
    chk("or_flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_neg, bus.rsp_err}), 0);
    @(posedge clk);
    #1 issue(16'h1234, 16'h5678, 3'b101);
    waitRsp("illegal_latency", 1);
    chk("illegal_err", 32'(bus.rsp_err), 1);
    chk("illegal_result", 32'(bus.rsp_result), 0);
    chk("illegal_func", 32'(bus.alu_func), 0);
    @(posedge clk);
    #1 issue(16'h00FF, 16'h0001, 3'b000);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", 32'({bus.rsp_valid, bus.req_ready, bus.alu_cin, bus.rsp_err}), 0);
    chk("midrst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_func}), 0);
    chk("midrst_result", 32'(bus.rsp_result), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(bus.rsp_valid), 0);
    end
    @(posedge clk);
    #1 issue(16'h0001, 16'h0001, 3'b000);
    waitRsp("fresh_latency", 3);
    chk("fresh_result", 32'(bus.rsp_result), 32'h0002);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
